// File: rtl/pulse_div_pkg.sv
// pulse_div_pkg: shared constants and the capture clamp helper for the
// programmable pulse divider (pulse_div_prog, pulse_div_shadow).
package pulse_div_pkg;

   localparam int unsigned PULSE_DIV_MIN_DIV = 2;
   localparam int unsigned PULSE_DIV_MIN_PW  = 1;

   // Clamp val into [lo, hi]; lo wins if the range is empty.
   function automatic logic [31:0] pulse_div_clamp(
      input logic [31:0] val,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      logic [31:0] r;
      r = val;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/pulse_div_shadow.sv
// pulse_div_shadow: clamps and double-buffers divisor/width requests.
// Ports: clk (falling edge), rst_n (async low), div_load/div_in/pw_in
// capture request, tc apply strobe, apply_div/apply_pw values to load
// at tc, load_pending flag.
module pulse_div_shadow
   import pulse_div_pkg::*;
#(
   parameter int unsigned BITS        = 16,
   parameter int unsigned DEFAULT_DIV = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            div_load,
   input  logic [BITS-1:0] div_in,
   input  logic [BITS-1:0] pw_in,
   input  logic            tc,
   output logic [BITS-1:0] apply_div,
   output logic [BITS-1:0] apply_pw,
   output logic            load_pending
);

   logic [BITS-1:0] div_sh_q, div_sh_d;
   logic [BITS-1:0] pw_sh_q, pw_sh_d;
   logic            pend_q, pend_d;
   logic [BITS-1:0] div_cl, pw_cl;

   always_comb begin
      div_cl = BITS'(pulse_div_clamp(32'(div_in),
                                     PULSE_DIV_MIN_DIV,
                                     32'hFFFF_FFFF));
      pw_cl  = BITS'(pulse_div_clamp(32'(pw_in),
                                     PULSE_DIV_MIN_PW,
                                     32'(div_cl) - 32'd1));
      div_sh_d = div_load ? div_cl : div_sh_q;
      pw_sh_d  = div_load ? pw_cl  : pw_sh_q;
      // A load on the tc edge bypasses the shadow, so never pends.
      pend_d = pend_q;
      if (div_load) pend_d = 1'b1;
      if (tc)       pend_d = 1'b0;
      apply_div = div_sh_d;
      apply_pw  = pw_sh_d;
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_sh_q <= BITS'(DEFAULT_DIV);
         pw_sh_q  <= BITS'(PULSE_DIV_MIN_PW);
         pend_q   <= 1'b0;
      end else begin
         div_sh_q <= div_sh_d;
         pw_sh_q  <= pw_sh_d;
         pend_q   <= pend_d;
      end
   end

   assign load_pending = pend_q;

endmodule

// File: rtl/pulse_div_prog.sv
// pulse_div_prog: programmable clk divider with registered pulse of
// programmable width; divisor/width applied only at terminal count.
// Ports: clk (falling edge), rst_n (async low), en, div_in, pw_in,
// div_load, sync (only with PULSE_DIV_SYNC_EN), pulse, count,
// load_pending. Optional phase restart: `define PULSE_DIV_SYNC_EN.
module pulse_div_prog
   import pulse_div_pkg::*;
#(
   parameter int unsigned BITS        = 16,
   parameter int unsigned DEFAULT_DIV = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [BITS-1:0] div_in,
   input  logic [BITS-1:0] pw_in,
   input  logic            div_load,
`ifdef PULSE_DIV_SYNC_EN
   input  logic            sync,
`endif
   output logic            pulse,
   output logic [BITS-1:0] count,
   output logic            load_pending
);

   logic [BITS-1:0] count_q, count_d;
   logic            pulse_q, pulse_d;
   logic [BITS-1:0] div_act_q, div_act_d;
   logic [BITS-1:0] pw_act_q, pw_act_d;
   logic [BITS-1:0] apply_div, apply_pw;
   logic            tc;

   pulse_div_shadow #(
      .BITS        (BITS),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_shadow (
      .clk          (clk),
      .rst_n        (rst_n),
      .div_load     (div_load),
      .div_in       (div_in),
      .pw_in        (pw_in),
      .tc           (tc),
      .apply_div    (apply_div),
      .apply_pw     (apply_pw),
      .load_pending (load_pending)
   );

`ifdef PULSE_DIV_SYNC_EN
   logic sync_q, sync_d;
   logic sync_evt_q, sync_evt_d;

   // Rising edge seen while enabled forces tc on the next edge; a
   // coinciding natural tc merges into the same single reload.
   always_comb begin
      sync_d     = sync;
      sync_evt_d = en & sync & ~sync_q;
      tc         = en & ((count_q == '0) | sync_evt_q);
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 1'b0;
         sync_evt_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         sync_evt_q <= sync_evt_d;
      end
   end
`else
   always_comb tc = en & (count_q == '0);
`endif

   always_comb begin
      div_act_d = tc ? apply_div : div_act_q;
      pw_act_d  = tc ? apply_pw  : pw_act_q;
      count_d   = count_q;
      if (tc)      count_d = div_act_d - BITS'(1);
      else if (en) count_d = count_q - BITS'(1);
      // High for the first W counts of the period (D-1 .. D-W).
      pulse_d = en & (count_d >= (div_act_d - pw_act_d));
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         pulse_q   <= 1'b0;
         div_act_q <= BITS'(DEFAULT_DIV);
         pw_act_q  <= BITS'(PULSE_DIV_MIN_PW);
      end else begin
         count_q   <= count_d;
         pulse_q   <= pulse_d;
         div_act_q <= div_act_d;
         pw_act_q  <= pw_act_d;
      end
   end

   assign count = count_q;
   assign pulse = pulse_q;

endmodule

// File: tb/tb_pulse_div_prog.sv
// tb_pulse_div_prog: vector table + scoreboard bench for pulse_div_prog
// (BITS=8, DEFAULT_DIV=10); sync cases built when PULSE_DIV_SYNC_EN set.
module tb_pulse_div_prog;

   typedef struct {
      logic       en;
      logic       ld;
      logic [7:0] d;
      logic [7:0] w;
      logic [7:0] c;
      logic       p;
      logic       lp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] div_in;
   logic [7:0] pw_in;
   logic       div_load;
   logic       sync;
   logic       pulse;
   logic [7:0] count;
   logic       load_pending;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   pulse_div_prog #(
      .BITS        (8),
      .DEFAULT_DIV (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .div_in       (div_in),
      .pw_in        (pw_in),
      .div_load     (div_load),
`ifdef PULSE_DIV_SYNC_EN
      .sync         (sync),
`endif
      .pulse        (pulse),
      .count        (count),
      .load_pending (load_pending)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic l,
                               input int d, input int w, input int c,
                               input logic p, input logic lp);
      vec_t v;
      v.en = e; v.ld = l;
      v.d = 8'(d); v.w = 8'(w); v.c = 8'(c);
      v.p = p; v.lp = lp;
      return v;
   endfunction

   function automatic void add(input logic e, input logic l,
                               input int d, input int w, input int c,
                               input logic p, input logic lp);
      vecs.push_back(mk(e, l, d, w, c, p, lp));
   endfunction

   // Drive at posedge, DUT updates on negedge, compare at next posedge.
   task automatic step(input vec_t v);
      vec_t e;
      en       = v.en;
      div_load = v.ld;
      div_in   = v.d;
      pw_in    = v.w;
      exp_q.push_back(v);
      @(posedge clk);
      e = exp_q.pop_front();
      chk($sformatf("step%0d count", step_no), 32'(count), 32'(e.c));
      chk($sformatf("step%0d pulse", step_no), 32'(pulse), 32'(e.p));
      chk($sformatf("step%0d pending", step_no),
          32'(load_pending), 32'(e.lp));
      step_no++;
   endtask

   initial begin
      // 1: free run, D=10
      for (int i = 0; i <= 20; i++)
         add(1, 0, 0, 0, 9 - (i % 10), (i % 10) == 0, 0);
      // 2: load D=5 W=2; pending for counts 6..0
      add(1, 0, 0, 0, 8, 0, 0);
      add(1, 0, 0, 0, 7, 0, 0);
      add(1, 1, 5, 2, 6, 0, 1);
      for (int c = 5; c >= 0; c--) add(1, 0, 0, 0, c, 0, 1);
      for (int k = 0; k < 2; k++)
         for (int c = 4; c >= 0; c--) add(1, 0, 0, 0, c, c >= 3, 0);
      // 3a: D=1 W=0 at tc -> D=2 W=1
      add(1, 1, 1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 1, 0);
      // 3b: D=4 W=7 mid-period -> W=3
      add(1, 1, 4, 7, 0, 0, 1);
      for (int k = 0; k < 2; k++)
         for (int c = 3; c >= 0; c--) add(1, 0, 0, 0, c, c >= 1, 0);
      // 4: en low at count 3 for 5 cycles
      add(1, 0, 0, 0, 3, 1, 0);
      for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 3, 0, 0);
      add(1, 0, 0, 0, 2, 1, 0);
      add(1, 0, 0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 3, 1, 0);
      // 5: D=6 W=2 loaded on a tc edge
      add(1, 0, 0, 0, 2, 1, 0);
      add(1, 0, 0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 6, 2, 5, 1, 0);
      add(1, 0, 0, 0, 4, 1, 0);
      for (int c = 3; c >= 0; c--) add(1, 0, 0, 0, c, 0, 0);
      add(1, 0, 0, 0, 5, 1, 0);
      add(1, 1, 3, 1, 4, 1, 1);

      rst_n = 1'b0; en = 1'b0; div_load = 1'b0;
      div_in = '0; pw_in = '0; sync = 1'b0;
      repeat (2) @(posedge clk);
      chk("reset count", 32'(count), 0);
      chk("reset pulse", 32'(pulse), 0);
      chk("reset pending", 32'(load_pending), 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // Reset with a load pending discards it; D returns to 10.
      rst_n = 1'b0;
      #1;
      chk("midreset count", 32'(count), 0);
      chk("midreset pulse", 32'(pulse), 0);
      chk("midreset pending", 32'(load_pending), 0);
      @(posedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 10; i++)
         step(mk(1, 0, 0, 0, 9 - (i % 10), (i % 10) == 0, 0));

`ifdef PULSE_DIV_SYNC_EN
      // count now 9: run to 4, raise sync
      for (int c = 8; c >= 4; c--) step(mk(1, 0, 0, 0, c, 0, 0));
      sync = 1'b1;
      step(mk(1, 0, 0, 0, 3, 0, 0));
      step(mk(1, 0, 0, 0, 9, 1, 0));
      sync = 1'b0;
      for (int c = 8; c >= 1; c--) step(mk(1, 0, 0, 0, c, 0, 0));
      // sync lands on natural tc: one reload only
      sync = 1'b1;
      step(mk(1, 0, 0, 0, 0, 0, 0));
      step(mk(1, 0, 0, 0, 9, 1, 0));
      sync = 1'b0;
      step(mk(1, 0, 0, 0, 8, 0, 0));
      step(mk(1, 0, 0, 0, 7, 0, 0));
`endif

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d leftover expected 0",
                  exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
